serial_adder: RTL and testbench
===============================

// Module: serial_adder
// PURPOSE
//   Bit-serial WIDTH-bit unsigned adder built from the half-adder cell plus a carry flip-flop.
//   Loads two operands on a start strobe and adds them LSB first, one bit per clock.
//   Presents the registered sum and carry-out with a one-cycle done pulse.
//   Sits downstream of operand registers and feeds result consumers that use the start/done handshake.
// PARAMETERS
//   WIDTH  8  operand/sum width in bits; legal range WIDTH >= 2
// PORTS
//   clk    input   1      single clock; all state changes on the rising edge
//   rst_n  input   1      asynchronous, active-low reset
//   start  input   1      request; sampled on the rising edge while the block is not busy
//   a      input   WIDTH  operand A; captured on the edge that accepts start
//   b      input   WIDTH  operand B; captured on the edge that accepts start
//   busy   output  1      high while in RUN
//   done   output  1      one-cycle pulse; sum and cout are valid from this cycle on
//   sum    output  WIDTH  registered result of (a+b) mod 2^WIDTH
//   cout   output  1      registered carry out of bit WIDTH-1
// BEHAVIOUR
//   Reset
//     - rst_n low forces state to IDLE immediately (asynchronous).
//     - Clears busy, done, sum, cout, the carry flip-flop, the bit counter and the operand/sum shift registers.
//   States: IDLE, RUN, DONE
//     - busy = (state == RUN).
//     - done is registered and high only in DONE.
//   IDLE or DONE with start = 1 at edge E0
//     - Load shift registers: sa <= a, sb <= b.
//     - carry <= 0, cnt <= 0, state -> RUN.
//   IDLE or DONE with start = 0
//     - Go to or stay in IDLE.
//     - sum and cout hold their last values.
//   RUN, one bit per edge (bit i)
//     - Bit i is taken from sa[0] and sb[0].
//     - sbit = sa[0] ^ sb[0] ^ carry.
//     - carry <= (sa[0] & sb[0]) | (carry & (sa[0] ^ sb[0])), i.e. two half adders plus OR.
//     - sa and sb shift right by one.
//     - sbit enters the MSB of an internal sum shift register, which also shifts right.
//     - cnt increments.
//   RUN, last edge (cnt == WIDTH-1)
//     - Capture the final shifted sum into sum.
//     - Capture the final carry into cout.
//     - state -> DONE.
//   Latency
//     - done goes high on edge E_WIDTH, i.e. WIDTH edges after the accepting edge E0.
//     - done stays high for exactly one cycle.
//   Busy rules
//     - start is ignored while busy; operands are not reloaded.
//     - a and b may change freely during RUN.
//   Back-to-back operation
//     - start in the DONE cycle is accepted, giving a new RUN with no IDLE gap.
//     - sum and cout keep the previous result until the new done.
//   Outputs stay stable except at the final RUN edge and at reset.
//   Wrap-around: sum wraps modulo 2^WIDTH; the overflow shows only in cout.
//   Reset mid-RUN aborts the operation; no done is produced for the aborted operation.
// TESTING (WIDTH = 8)
//   - Reset released, idle 3 cycles -> busy=0, done=0, sum=0x00, cout=0.
//   - Start a=0x5A b=0x3C -> busy 8 cycles, done on edge E8, sum=0x96, cout=0.
//   - Start a=0xFF b=0x01 -> sum=0x00, cout=1.
//   - Start a=0xFF b=0xFF -> sum=0xFE, cout=1.
//     Then start a=0x00 b=0x00 in the done cycle -> busy with no gap, then sum=0x00, cout=0.
//   - Start a=0x12 b=0x34; at E3 pulse start with a=0xFF b=0xFF -> ignored, result sum=0x46, cout=0.
//   - Start a=0xF0 b=0x0F; drop rst_n at E4 -> busy=0 and sum=0 at once, no done.
//     After release, a new add 0x01+0x01 -> sum=0x02.

Source files
------------

// File: rtl/serial_adder_if.sv
// Start/done handshake bundle between an operand source and the serial adder.
//   master : drives start, a, b; observes busy, done, sum, cout
//   slave  : the adder; the reverse directions
interface serial_adder_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit unsigned adder: two half-adder cells plus a carry flop,
// LSB first, one bit per clock. A start accepted in IDLE or DONE loads the
// operands; WIDTH edges later sum/cout are registered and done pulses once.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus.start  : request, ignored while busy
//   bus.a/b    : operands, captured on the accepting edge
//   bus.busy   : high while running
//   bus.done   : one-cycle pulse when sum/cout update
//   bus.sum    : (a+b) mod 2^WIDTH, held until the next result
//   bus.cout   : carry out of bit WIDTH-1
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_adder_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam int unsigned SSR_W = WIDTH - 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sa_q, sa_d;
    logic [WIDTH-1:0]   sb_q, sb_d;
    // Holds sum bits 0..i-1; the bit of the current edge completes the word.
    logic [SSR_W-1:0]   ssr_q, ssr_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               last_c;
    logic               ha0_s_c, ha0_c_c, ha1_s_c, ha1_c_c, carry_nxt_c;

    // Full adder from two half adders plus OR.
    assign ha0_s_c     = sa_q[0] ^ sb_q[0];
    assign ha0_c_c     = sa_q[0] & sb_q[0];
    assign ha1_s_c     = ha0_s_c ^ carry_q;
    assign ha1_c_c     = ha0_s_c & carry_q;
    assign carry_nxt_c = ha0_c_c | ha1_c_c;

    assign last_c = (cnt_q == CNT_W'(WIDTH - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN:   if (last_c) state_d = S_DONE;
            default: state_d = bus.start ? S_RUN : S_IDLE;
        endcase
    end

    // Datapath and output next values.
    always_comb begin
        sa_d    = sa_q;
        sb_d    = sb_q;
        ssr_d   = ssr_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            S_RUN: begin
                sa_d    = WIDTH'(sa_q >> 1);
                sb_d    = WIDTH'(sb_q >> 1);
                ssr_d   = SSR_W'({ha1_s_c, ssr_q} >> 1);
                carry_d = carry_nxt_c;
                cnt_d   = cnt_q + CNT_W'(1);
                if (last_c) begin
                    sum_d  = {ha1_s_c, ssr_q};
                    cout_d = carry_nxt_c;
                    cnt_d  = '0;
                end
            end
            default: begin
                if (bus.start) begin
                    sa_d    = bus.a;
                    sb_d    = bus.b;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                end
            end
        endcase
        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa_q    <= '0;
            sb_q    <= '0;
            ssr_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            ssr_q   <= ssr_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder (WIDTH = 8): vector table plus hand-written corner
// sequences; a scoreboard queue holds expected {cout,sum} per accepted start.
module tb_serial_adder;
    localparam int unsigned W = 8;

    logic clk;
    logic rst_n;

    serial_adder_if #(.WIDTH(W)) bus ();

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [W:0]   sb_q[$];
    logic [W-1:0] held_sum  = '0;
    logic         held_cout = 1'b0;
    logic         prev_done = 1'b0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] s;
        logic         c;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Result monitor: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.done) begin
                if (prev_done) check("done_width", 32'(2), 32'(1));
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 32'(1), 32'(0));
                end else begin
                    logic [W:0] e;
                    e = sb_q.pop_front();
                    check("sum",  32'(bus.sum),  32'(e[W-1:0]));
                    check("cout", 32'(bus.cout), 32'(e[W]));
                    held_sum  = e[W-1:0];
                    held_cout = e[W];
                end
            end
            prev_done = bus.done;
        end else begin
            prev_done = 1'b0;
        end
    end

    // Drive a start away from the rising edge; returns just after the accepting edge.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] m;
        m = {1'b0, a} + {1'b0, b};
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        sb_q.push_back(m);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
    endtask

    // Wait for done; skip = accepting-edge-relative edges already consumed by the caller.
    // Returns on the falling edge where done is observed.
    task automatic wait_done(input string name, input int skip);
        int  busy_cnt;
        int  lat;
        bit  stable;
        bit  seen;
        busy_cnt = skip;
        lat      = -1;
        stable   = 1'b1;
        seen     = 1'b0;
        for (int j = 1; j <= 20; j++) begin
            @(negedge clk);
            if (bus.done) begin
                lat  = j - 1 + skip;
                seen = 1'b1;
                check({name, "_busy_at_done"}, 32'(bus.busy), 32'(0));
                break;
            end
            if (bus.busy) busy_cnt++;
            if (bus.sum !== held_sum || bus.cout !== held_cout) stable = 1'b0;
        end
        if (!seen) check({name, "_timeout"}, 32'(0), 32'(1));
        check({name, "_latency"}, 32'(lat), 32'(W));
        check({name, "_busy_cycles"}, 32'(busy_cnt), 32'(W));
        check({name, "_hold"}, 32'(stable), 32'(1));
    endtask

    initial begin
        logic [W-1:0] ra, rb;

        vecs[0] = '{a: 8'h5A, b: 8'h3C, s: 8'h96, c: 1'b0};
        vecs[1] = '{a: 8'hFF, b: 8'h01, s: 8'h00, c: 1'b1};
        vecs[2] = '{a: 8'h80, b: 8'h80, s: 8'h00, c: 1'b1};
        vecs[3] = '{a: 8'hAA, b: 8'h55, s: 8'hFF, c: 1'b0};
        vecs[4] = '{a: 8'h01, b: 8'h7F, s: 8'h80, c: 1'b0};
        vecs[5] = '{a: 8'hC3, b: 8'h3D, s: 8'h00, c: 1'b1};
        vecs[6] = '{a: 8'h00, b: 8'h00, s: 8'h00, c: 1'b0};

        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'(0));
        check("rst_done", 32'(bus.done), 32'(0));
        check("rst_sum",  32'(bus.sum),  32'(0));
        check("rst_cout", 32'(bus.cout), 32'(0));

        // Table vectors; sanity-check the table against the bench's own arithmetic.
        for (int i = 0; i < 7; i++) begin
            logic [W:0] m;
            m = {1'b0, vecs[i].a} + {1'b0, vecs[i].b};
            check("vec_table", 32'(m), 32'({vecs[i].c, vecs[i].s}));
            launch(vecs[i].a, vecs[i].b);
            wait_done("vec", 0);
            check("vec_sum_direct", 32'(bus.sum), 32'(vecs[i].s));
            @(negedge clk);
            check("done_drop", 32'(bus.done), 32'(0));
            check("idle_busy", 32'(bus.busy), 32'(0));
            check("idle_hold", 32'(bus.sum), 32'(vecs[i].s));
        end

        // Random operands, expectation from the integer model inside launch().
        for (int i = 0; i < 6; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            launch(ra, rb);
            wait_done("rand", 0);
            @(negedge clk);
        end

        // Back-to-back: new start in the done cycle, no idle gap.
        launch(8'hFF, 8'hFF);
        wait_done("b2b_first", 0);
        launch(8'h00, 8'h00);
        @(negedge clk);
        check("b2b_busy_nogap", 32'(bus.busy), 32'(1));
        check("b2b_done_low", 32'(bus.done), 32'(0));
        check("b2b_sum_held", 32'(bus.sum), 32'(8'hFE));
        check("b2b_cout_held", 32'(bus.cout), 32'(1));
        wait_done("b2b_second", 1);
        @(negedge clk);

        // Start while busy is ignored and operands are not reloaded.
        launch(8'h12, 8'h34);
        repeat (2) @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.a     = 8'hFF;
        bus.b     = 8'hFF;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done("ignore", 3);
        check("ignore_sum", 32'(bus.sum), 32'(8'h46));
        @(negedge clk);
        check("ignore_no_second", 32'(bus.busy), 32'(0));

        // Reset mid-run aborts without a done.
        launch(8'hF0, 8'h0F);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        void'(sb_q.pop_back());
        held_sum  = '0;
        held_cout = 1'b0;
        #1;
        check("abort_busy", 32'(bus.busy), 32'(0));
        check("abort_sum",  32'(bus.sum),  32'(0));
        check("abort_cout", 32'(bus.cout), 32'(0));
        check("abort_done", 32'(bus.done), 32'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        begin
            int dcnt;
            dcnt = 0;
            for (int j = 0; j < 12; j++) begin
                @(negedge clk);
                if (bus.done || bus.busy) dcnt++;
            end
            check("abort_no_done", 32'(dcnt), 32'(0));
        end
        launch(8'h01, 8'h01);
        wait_done("post_reset", 0);
        check("post_reset_sum", 32'(bus.sum), 32'(8'h02));
        @(negedge clk);

        check("scoreboard_empty", 32'(sb_q.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
